// File: rtl/alu_result_stage.sv
// Registered output stage of the 8-bit ALU: 2-entry skid FIFO with status flags,
// accumulator write-back and a saturating stall counter. Define ALU_RESULT_PARITY_EN to store parity.
module alu_result_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [2:0] in_sel,
  input  logic       in_carry,
  input  logic       in_acc_wr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [2:0] out_sel,
  output logic [3:0] out_flags,
  output logic [7:0] acc,
  output logic [7:0] stall_cnt
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned CNT_W  = 2;
`ifdef ALU_RESULT_PARITY_EN
  localparam int unsigned FLAG_W = 4;
`else
  localparam int unsigned FLAG_W = 3;
`endif

  localparam logic [CNT_W-1:0]  CNT_EMPTY = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(2);
  localparam logic [DATA_W-1:0] STALL_MAX = {DATA_W{1'b1}};

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [FLAG_W-1:0] flags;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            head_q, head_d;
  entry_t            tail_q, tail_d;
  entry_t            new_entry;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] stall_q, stall_d;
  logic              accept;
  logic              pop;

  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != CNT_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Flags are captured at accept time, packed {P, C, N, Z} (P only when enabled).
  always_comb begin
    new_entry      = '0;
    new_entry.sel  = in_sel;
    new_entry.data = in_data;
`ifdef ALU_RESULT_PARITY_EN
    new_entry.flags = {^in_data, in_carry, in_data[DATA_W-1], (in_data == '0)};
`else
    new_entry.flags = {in_carry, in_data[DATA_W-1], (in_data == '0)};
`endif
  end

  // Head holds the oldest entry; unused slots are kept at zero so idle outputs read 0.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({accept, pop})
      2'b10: begin
        if (count_q == CNT_EMPTY) head_d = new_entry;
        else                      tail_d = new_entry;
        count_d = count_q + CNT_W'(1);
      end
      2'b01: begin
        head_d  = tail_q;
        tail_d  = '0;
        count_d = count_q - CNT_W'(1);
      end
      2'b11: begin
        head_d = new_entry;
      end
      default: ;
    endcase
  end

  always_comb begin
    acc_d   = acc_q;
    stall_d = stall_q;
    if (accept && in_acc_wr) acc_d = in_data;
    if (out_valid && !out_ready && (stall_q != STALL_MAX)) stall_d = stall_q + DATA_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CNT_EMPTY;
      acc_q   <= '0;
      stall_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      stall_q <= stall_d;
    end
  end

  assign out_data  = head_q.data;
  assign out_sel   = head_q.sel;
`ifdef ALU_RESULT_PARITY_EN
  assign out_flags = head_q.flags;
`else
  assign out_flags = {1'b0, head_q.flags};
`endif
  assign acc       = acc_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: flag vector table plus scoreboarded sequences.
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_sel;
  logic       in_carry;
  logic       in_acc_wr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_sel;
  logic [3:0] out_flags;
  logic [7:0] acc;
  logic [7:0] stall_cnt;

`ifdef ALU_RESULT_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .in_carry(in_carry), .in_acc_wr(in_acc_wr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel),
    .out_flags(out_flags), .acc(acc), .stall_cnt(stall_cnt)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] data;
    logic [2:0] sel;
    logic       carry;
    logic [3:0] flags;
  } vec_t;

  vec_t        vecs[7];
  logic [14:0] sb[$];
  int          pops = 0;
  int          stall_m = 0;
  logic [7:0]  acc_m = 8'h00;
  bit          armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_flags(input logic [7:0] d, input logic c);
    logic p;
    p = PAR_EN ? ^d : 1'b0;
    return {p, c, d[7], (d == 8'h00)};
  endfunction

  // Scoreboard and reference models, updated on each rising edge from pre-edge values.
  always @(posedge clk) begin
    if (!rst_n) begin
      sb.delete();
      acc_m   = 8'h00;
      stall_m = 0;
      armed   = 1'b1;
    end else if (armed) begin
      if (out_valid && !out_ready && stall_m != 255) stall_m++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("pop_unexpected", 32'(1), 32'(0));
        else begin
          check("pop_entry", 32'({out_sel, out_flags, out_data}), 32'(sb[0]));
          void'(sb.pop_front());
          pops++;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back({in_sel, model_flags(in_data, in_carry), in_data});
        if (in_acc_wr) acc_m = in_data;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("in_ready", 32'(in_ready), 32'(sb.size() != 2));
      check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      if (sb.size() == 0) check("idle_zero", 32'({out_sel, out_flags, out_data}), 32'(0));
      check("acc", 32'(acc), 32'(acc_m));
      check("stall_cnt", 32'(stall_cnt), 32'(stall_m));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one beat and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] d, input logic c, input logic [2:0] s, input logic w);
    bit done;
    done      = 1'b0;
    in_valid  = 1'b1;
    in_data   = d;
    in_carry  = c;
    in_sel    = s;
    in_acc_wr = w;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) check("send_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0;
    vecs[0] = '{8'h00, 3'd0, 1'b0, 4'b0001};
    vecs[1] = '{8'h80, 3'd1, 1'b1, 4'b1110};
    vecs[2] = '{8'hFF, 3'd2, 1'b0, 4'b0010};
    vecs[3] = '{8'h01, 3'd3, 1'b1, 4'b1100};
    vecs[4] = '{8'h7F, 3'd5, 1'b0, 4'b1000};
    vecs[5] = '{8'h03, 3'd7, 1'b1, 4'b0100};
    vecs[6] = '{8'hA5, 3'd6, 1'b0, 4'b0010};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_sel = 3'd0;
    in_carry = 1'b0; in_acc_wr = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'(1));
    check("reset_out_valid", 32'(out_valid), 32'(0));
    check("reset_acc", 32'(acc), 32'(0));

    // Flag table: each beat appears the cycle after its accept.
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].data, vecs[i].carry, vecs[i].sel, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);
      check("vec_valid", 32'(out_valid), 32'(1));
      check("vec_data", 32'(out_data), 32'(vecs[i].data));
      check("vec_sel", 32'(out_sel), 32'(vecs[i].sel));
      check("vec_flags", 32'(out_flags), 32'(PAR_EN ? vecs[i].flags : {1'b0, vecs[i].flags[2:0]}));
      @(posedge clk);
      #1;
    end
    idle(2);

    // Back-pressure fill: third beat held upstream.
    p0 = pops;
    out_ready = 1'b0;
    send(8'h11, 1'b0, 3'd1, 1'b0);
    send(8'h22, 1'b0, 3'd2, 1'b0);
    in_data = 8'h33; in_sel = 3'd3;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_head", 32'(out_data), 32'(8'h11));
    end
    out_ready = 1'b1;
    send(8'h33, 1'b0, 3'd3, 1'b0);
    in_valid = 1'b0;
    idle(4);
    check("bp_delivered", 32'(pops - p0), 32'(3));

    // Continuous push/pop at occupancy 1.
    p0 = pops;
    for (int i = 1; i <= 10; i++) begin
      send(8'(i), 1'b0, 3'(i), 1'b0);
      check("stream_valid", 32'(out_valid), 32'(1));
      check("stream_ready", 32'(in_ready), 32'(1));
    end
    in_valid = 1'b0;
    idle(3);
    check("stream_delivered", 32'(pops - p0), 32'(10));

    // Accumulator writes only on accepted beats.
    send(8'h5A, 1'b0, 3'd0, 1'b1);
    check("acc_write", 32'(acc), 32'(8'h5A));
    send(8'hFF, 1'b0, 3'd0, 1'b0);
    in_valid = 1'b0;
    check("acc_hold", 32'(acc), 32'(8'h5A));
    idle(3);
    out_ready = 1'b0;
    send(8'hA1, 1'b0, 3'd0, 1'b0);
    send(8'hA2, 1'b0, 3'd0, 1'b0);
    in_data = 8'h77; in_acc_wr = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("acc_blocked", 32'(acc), 32'(8'h5A));
    end
    in_valid = 1'b0; in_acc_wr = 1'b0;
    out_ready = 1'b1;
    idle(4);

    // Stall counter saturation, then cleared by reset (beat offered on the reset edge is ignored).
    out_ready = 1'b0;
    send(8'h42, 1'b1, 3'd4, 1'b0);
    in_valid = 1'b0;
    idle(300);
    check("stall_sat", 32'(stall_cnt), 32'(255));
    idle(2);
    check("stall_hold", 32'(stall_cnt), 32'(255));
    in_valid = 1'b1; in_data = 8'h99; in_acc_wr = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1; in_valid = 1'b0; in_acc_wr = 1'b0;
    check("stall_reset", 32'(stall_cnt), 32'(0));
    check("rst_accept_ignored", 32'(out_valid), 32'(0));
    check("rst_acc_ignored", 32'(acc), 32'(0));

    // Reset mid-stream drops both entries.
    send(8'hC3, 1'b0, 3'd1, 1'b1);
    send(8'h3C, 1'b1, 3'd2, 1'b1);
    in_valid = 1'b0; in_acc_wr = 1'b0;
    check("mid_acc", 32'(acc), 32'(8'h3C));
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("mid_out_valid", 32'(out_valid), 32'(0));
    check("mid_flags", 32'(out_flags), 32'(0));
    check("mid_acc_clr", 32'(acc), 32'(0));
    check("mid_in_ready", 32'(in_ready), 32'(1));
    p0 = pops;
    out_ready = 1'b1;
    idle(5);
    check("mid_no_stale", 32'(pops - p0), 32'(0));
    check("mid_still_empty", 32'(out_valid), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
